// File: rtl/mem_rdata_decoder.sv
// Load-path read-data decoder: issues a memory read, waits for ready or timeout, then lane-selects and extends.
// Optional build macro MEM_RDATA_MISALIGN_EN rejects misaligned half/word loads in IDLE.
module mem_rdata_decoder #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [1:0]  iOfs,
  input  logic [1:0]  iDs,
  input  logic        iSext,
  input  logic [4:0]  iRd,
  output logic        oBusy,
  output logic        oMemRe,
  input  logic        iMemRdy,
  input  logic [31:0] iMemD,
  output logic [31:0] oD,
  output logic [4:0]  oRd,
  output logic        oValid,
  output logic        oErr
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [1:0]  ofs_r, ds_r;
  logic        sext_r;
  logic [4:0]  rd_hold_r;
  logic        lat_load_s, reject_s;
  logic        mem_re_nxt_s, valid_nxt_s, err_nxt_s;
  logic [31:0] d_nxt_s;
  logic [4:0]  rd_nxt_s;

  // Big-endian lane select plus zero/sign extension; same lane mapping as the store encoder.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] ofs,
                                          input logic [1:0] ds, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = 16'h0000;
    r = w;
    case (ds)
      2'b10: begin
        case (ofs)
          2'b00:   b = w[31:24];
          2'b01:   b = w[23:16];
          2'b10:   b = w[15:8];
          default: b = w[7:0];
        endcase
        r = {{24{sext & b[7]}}, b};
      end
      2'b01: begin
        h = ofs[1] ? w[15:0] : w[31:16];
        r = {{16{sext & h[15]}}, h};
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Requests that never reach memory: illegal size, plus misalignment when enabled.
  always_comb begin
`ifdef MEM_RDATA_MISALIGN_EN
    reject_s = (iDs == 2'b11) ||
               ((iDs == 2'b01) && iOfs[0]) ||
               ((iDs == 2'b00) && (iOfs != 2'b00));
`else
    reject_s = (iDs == 2'b11);
`endif
  end

  assign oBusy = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (iReq && !reject_s) state_nxt_s = WAIT;
        else                   state_nxt_s = IDLE;
      end
      WAIT: begin
        if (iMemRdy || (cnt_r == TO_LAST)) state_nxt_s = IDLE;
        else                               state_nxt_s = WAIT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and request latch.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    lat_load_s   = 1'b0;
    mem_re_nxt_s = 1'b0;
    valid_nxt_s  = 1'b0;
    err_nxt_s    = 1'b0;
    d_nxt_s      = oD;
    rd_nxt_s     = oRd;
    case (state_r)
      IDLE: begin
        if (iReq) begin
          if (reject_s) begin
            err_nxt_s = 1'b1;
          end else begin
            lat_load_s   = 1'b1;
            cnt_nxt_s    = 8'd0;
            mem_re_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      WAIT: begin
        if (iMemRdy) begin
          valid_nxt_s = 1'b1;
          d_nxt_s     = extract(iMemD, ofs_r, ds_r, sext_r);
          rd_nxt_s    = rd_hold_r;
        end else if (cnt_r == TO_LAST) begin
          err_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s    = cnt_r + 8'd1;
          mem_re_nxt_s = 1'b1;
        end
      end
      default: begin
        cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Output, counter and request-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 8'd0;
      oMemRe    <= 1'b0;
      oValid    <= 1'b0;
      oErr      <= 1'b0;
      oD        <= 32'h0000_0000;
      oRd       <= 5'd0;
      ofs_r     <= 2'b00;
      ds_r      <= 2'b00;
      sext_r    <= 1'b0;
      rd_hold_r <= 5'd0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      oMemRe <= mem_re_nxt_s;
      oValid <= valid_nxt_s;
      oErr   <= err_nxt_s;
      oD     <= d_nxt_s;
      oRd    <= rd_nxt_s;
      if (lat_load_s) begin
        ofs_r     <= iOfs;
        ds_r      <= iDs;
        sext_r    <= iSext;
        rd_hold_r <= iRd;
      end else begin
        ofs_r     <= ofs_r;
        ds_r      <= ds_r;
        sext_r    <= sext_r;
        rd_hold_r <= rd_hold_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_rdata_decoder.sv
// Scoreboard bench for mem_rdata_decoder: driver pushes expected responses, negedge monitor pops and compares.
module tb_mem_rdata_decoder;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, iReq, iSext, iMemRdy;
  logic [1:0]  iOfs, iDs;
  logic [4:0]  iRd;
  logic [31:0] iMemD;
  logic        oBusy, oMemRe, oValid, oErr;
  logic [31:0] oD;
  logic [4:0]  oRd;

  mem_rdata_decoder #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .iReq(iReq), .iOfs(iOfs), .iDs(iDs), .iSext(iSext), .iRd(iRd),
    .oBusy(oBusy), .oMemRe(oMemRe), .iMemRdy(iMemRdy), .iMemD(iMemD),
    .oD(oD), .oRd(oRd), .oValid(oValid), .oErr(oErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          is_valid;
    int          cyc;
    logic [31:0] d;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_d = 32'h0;
  logic [4:0]  model_rd = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_reject(input int ds, input int ofs);
    bit r;
    r = (ds == 3);
`ifdef MEM_RDATA_MISALIGN_EN
    if (ds == 1 && (ofs % 2) == 1) r = 1'b1;
    if (ds == 0 && ofs != 0) r = 1'b1;
`endif
    return r;
  endfunction

  // Arithmetic reference: shift the addressed field down, mask, and wrap negative values.
  function automatic logic [31:0] ref_value(input int ds, input int ofs, input int sext,
                                            input logic [31:0] data);
    logic [31:0] v;
    if (ds == 0) return data;
    if (ds == 2) begin
      v = (data >> (8 * (3 - ofs))) & 32'h0000_00FF;
      if (sext != 0 && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = (data >> ((ofs >= 2) ? 0 : 16)) & 32'h0000_FFFF;
      if (sext != 0 && v >= 32'h0000_8000) v = v - 32'h0001_0000;
    end
    return v;
  endfunction

  // Monitor: every output pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (oValid || oErr) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got valid=%b err=%b want no pulse (cycle %0d)", oValid, oErr, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_valid", 32'(oValid), 32'(mon_e.is_valid));
        chk("resp_err", 32'(oErr), 32'(!mon_e.is_valid));
        chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("resp_oD", oD, mon_e.d);
        chk("resp_oRd", 32'(oRd), 32'(mon_e.rd));
        chk("re_on_resp", 32'(oMemRe), 32'd0);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the posedge starting the response cycle.
  // d = WAIT cycles without ready, so ready arrives in WAIT cycle d+1 (timeout if beyond TO).
  task automatic do_load(input int ds, input int ofs, input int sext, input int rd,
                         input logic [31:0] data, input int d, input bit noise);
    int   c0;
    exp_t e;
    c0 = cyc;
    iReq = 1'b1; iDs = 2'(ds); iOfs = 2'(ofs); iSext = 1'(sext); iRd = 5'(rd);
    iMemRdy = 1'b0;
    if (ref_reject(ds, ofs)) begin
      e.is_valid = 1'b0; e.cyc = c0 + 1; e.d = model_d; e.rd = model_rd;
    end else if (d + 1 <= TO) begin
      model_d = ref_value(ds, ofs, sext, data);
      model_rd = 5'(rd);
      e.is_valid = 1'b1; e.cyc = c0 + d + 2; e.d = model_d; e.rd = model_rd;
    end else begin
      e.is_valid = 1'b0; e.cyc = c0 + TO + 1; e.d = model_d; e.rd = model_rd;
    end
    sb.push_back(e);
    @(negedge clk);
    chk("busy_idle", 32'(oBusy), 32'd0);
    @(posedge clk); #1;
    if (ref_reject(ds, ofs)) begin
      iReq = 1'b0;
      @(negedge clk);
      chk("re_rejected", 32'(oMemRe), 32'd0);
      @(posedge clk); #1;
    end else begin
      for (int w = 1; w <= TO; w++) begin
        iReq = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        iDs = 2'($urandom_range(0, 3)); iOfs = 2'($urandom_range(0, 3));
        iRd = 5'($urandom_range(0, 31));
        iMemRdy = (w == d + 1);
        iMemD = (w == d + 1) ? data : $urandom;
        @(negedge clk);
        chk("re_wait", 32'(oMemRe), 32'd1);
        chk("busy_wait", 32'(oBusy), 32'd1);
        @(posedge clk); #1;
        if (w == d + 1) break;
      end
      iMemRdy = 1'b0;
      iReq = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iReq = 1'b0; iOfs = 2'b00; iDs = 2'b00; iSext = 1'b0; iRd = 5'd0;
    iMemRdy = 1'b0; iMemD = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_oD", oD, 32'h0);
    chk("rst_flags", {26'd0, oBusy, oMemRe, oValid, oErr, 2'b00}, 32'h0);
    chk("rst_oRd", 32'(oRd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_load(2, 0, 1, 3, 32'h8899AABB, 0, 1'b0);
    do_load(2, 3, 0, 4, 32'h8899AABB, 0, 1'b0);
    do_load(1, 2, 1, 5, 32'h8899AABB, 0, 1'b0);
    do_load(1, 0, 0, 6, 32'h8899AABB, 1, 1'b0);
    do_load(0, 0, 0, 17, 32'h8899AABB, 3, 1'b0);
    do_load(2, 1, 1, 7, 32'h00F00000, 2, 1'b1);
    do_load(2, 2, 1, 8, 32'h00007F00, 0, 1'b0);
    do_load(1, 1, 1, 9, 32'h12348001, 0, 1'b0);
    do_load(1, 3, 1, 10, 32'h12348001, 1, 1'b0);
    do_load(0, 0, 0, 11, 32'hDEADBEEF, TO, 1'b0);
    @(posedge clk); #1;
    do_load(0, 0, 0, 12, 32'hCAFEF00D, 0, 1'b0);
    do_load(0, 1, 0, 13, 32'h01234567, 0, 1'b0);
    do_load(3, 0, 1, 14, 32'h01234567, 0, 1'b0);
    do_load(1, 1, 0, 15, 32'hA5A55A5A, 0, 1'b0);

    // Reset during WAIT aborts silently; then back-to-back loads.
    iReq = 1'b1; iDs = 2'b00; iOfs = 2'b00; iSext = 1'b0; iRd = 5'd20;
    @(posedge clk); #1;
    iReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_d = 32'h0;
    model_rd = 5'd0;
    @(negedge clk);
    chk("midrst_oD", oD, 32'h0);
    chk("midrst_flags", {28'd0, oBusy, oMemRe, oValid, oErr}, 32'h0);
    chk("midrst_oRd", 32'(oRd), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    do_load(2, 2, 0, 21, 32'h11223344, 0, 1'b0);
    do_load(1, 2, 1, 22, 32'h5566F788, 0, 1'b0);
    do_load(0, 0, 0, 23, 32'h99AABBCC, 2, 1'b0);

    for (int i = 0; i < 200; i++) begin
      do_load($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 31), $urandom, $urandom_range(0, TO + 1),
              1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (TO + 4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
